pc_gen_unit: RTL and testbench
==============================

Name: pc_gen_unit

Overview:
- Parametrised fetch-stage program-counter generator; successor to the combinational PC incrementer.
- Owns the registered PC and computes PC+INC internally.
- Arbitrates between sequential increment, stall/back-pressure hold and branch/jump redirects from EX.
- Buffers a redirect that arrives while fetch cannot advance, and traps misaligned targets.

Parameters:
- XLEN, 32, width of all PC/target datapaths.
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset.
- INC, 4, sequential increment in bytes.
- ALIGN_BITS, 2, number of low target bits that must be zero (1 when compressed ISA enabled).
- TRAP_VECTOR, 32'h0000_0100, PC substituted for a misaligned redirect target.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- stall_f  input  1  hazard-unit fetch stall; PC must hold.
- imem_ready  input  1  instruction memory can accept a fetch this cycle.
- redirect_valid  input  1  taken branch/jump from EX, single-cycle pulse.
- redirect_target  input  XLEN  redirect destination, qualified by redirect_valid.
- pc_f  output  XLEN  registered current fetch PC.
- pc_plus_inc_f  output  XLEN  registered pc_f+INC, aligned with pc_f.
- fetch_valid  output  1  pc_f is a legitimate fetch; 0 means bubble/squash.
- redirect_pending  output  1  a buffered redirect is waiting (state WAIT).
- misalign_err  output  1  one-cycle registered pulse on a misaligned redirect.

Behaviour:
- One clock (clk), synchronous active-high reset (rst); all state updates on rising clk edge.
- Reset (rst=1 at an edge) values:
  - pc_f=RESET_VECTOR, pc_plus_inc_f=RESET_VECTOR+INC.
  - fetch_valid=0, redirect_pending=0, misalign_err=0.
  - pend_q=0, state=RUN.
- Reset overrides every other input in that cycle, including mid-WAIT (the pending redirect is discarded).
- First edge with rst=0 sets fetch_valid=1.
- adv = !stall_f && imem_ready.
- Effective target eff_t:
  - redirect_target when redirect_target[ALIGN_BITS-1:0]==0.
  - Otherwise TRAP_VECTOR; misalign_err=1 on the next cycle only.
- State RUN:
  - redirect_valid && adv: pc_f<=eff_t next edge (latency 1 cycle); fetch_valid<=1; stay RUN.
  - redirect_valid && !adv: pend_q<=eff_t; go WAIT; fetch_valid<=0; pc_f holds.
  - !redirect_valid && adv: pc_f<=pc_f+INC; fetch_valid<=1.
  - !redirect_valid && !adv: pc_f, pc_plus_inc_f, fetch_valid all hold.
- State WAIT:
  - redirect_pending=1; pc_f holds; fetch_valid=0.
  - New redirect_valid overwrites pend_q with its eff_t (latest wins).
  - adv: pc_f<=(redirect_valid ? eff_t : pend_q); go RUN; fetch_valid<=1.
- Redirect always beats sequential increment; stall_f never drops a redirect.
- Arithmetic is modulo 2^XLEN: pc_f+INC wraps silently, e.g. 32'hFFFF_FFFC+4 -> 0. No overflow flag.
- pc_plus_inc_f is always updated together with pc_f as (new pc_f)+INC; it is never combinational from inputs.
- No combinational path from any input to any output.
- redirect_target is ignored when redirect_valid=0.

Test Plan:
- Reset then free-run: rst=1 two cycles, then stall_f=0, imem_ready=1 -> pc_f 0x0,0x4,0x8,0xC; fetch_valid=1 from the first post-reset edge; pc_plus_inc_f 0x4,0x8,0xC,0x10.
- Stall hold: at pc_f=0x8 drive stall_f=1 for 3 cycles -> pc_f stays 0x8 for 3 cycles, then 0xC after release; no value skipped.
- Redirect during back-pressure:
  - At pc_f=0x10 drive imem_ready=0 and redirect 0x200 for one cycle -> redirect_pending=1, fetch_valid=0, pc_f=0x10.
  - Raise imem_ready two cycles later -> pc_f=0x200 next edge, redirect_pending=0.
- Latest redirect wins: in WAIT with pend_q=0x200, a second redirect 0x300 arrives, then adv -> pc_f=0x300; 0x200 is never fetched.
- Misaligned redirect: redirect_target=0x202 with adv=1 -> pc_f=TRAP_VECTOR (0x100) next cycle; misalign_err high exactly one cycle.
- Wrap and reset-mid-WAIT:
  - pc_f=0xFFFF_FFFC with adv -> pc_f=0x0, pc_plus_inc_f=0x4.
  - rst asserted while in WAIT -> pc_f=RESET_VECTOR, redirect_pending=0, pending target discarded.

Source files
------------

// File: rtl/pc_gen_unit.sv
// Fetch-stage program-counter generator: sequential increment, stall hold,
// branch/jump redirects with a one-entry buffer, and misaligned-target trapping.
module pc_gen_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter int              INC          = 4,
    parameter int              ALIGN_BITS   = 2,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            imem_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc_f,
    output logic [XLEN-1:0] pc_plus_inc_f,
    output logic            fetch_valid,
    output logic            redirect_pending,
    output logic            misalign_err
);

    typedef enum logic {
        RUN,
        WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_inc_q;
    logic [XLEN-1:0] pend_q, pend_d;
    logic            valid_q, valid_d;
    logic            misalign_q, misalign_d;

    logic            adv;
    logic            misaligned;
    logic [XLEN-1:0] eff_t;

    assign adv        = !stall_f && imem_ready;
    assign misaligned = |redirect_target[ALIGN_BITS-1:0];
    assign eff_t      = misaligned ? TRAP_VECTOR : redirect_target;

    // After reset, the first edge validates the reset vector itself rather
    // than stepping past it, so RESET_VECTOR is always the first fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        valid_d    = valid_q;
        misalign_d = redirect_valid && misaligned;

        case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    if (adv) begin
                        pc_d    = eff_t;
                        valid_d = 1'b1;
                    end else begin
                        pend_d  = eff_t;
                        state_d = WAIT;
                        valid_d = 1'b0;
                    end
                end else if (!valid_q) begin
                    valid_d = 1'b1;
                end else if (adv) begin
                    pc_d = pc_q + XLEN'(INC);
                end
            end
            WAIT: begin
                valid_d = 1'b0;
                if (adv) begin
                    pc_d    = redirect_valid ? eff_t : pend_q;
                    state_d = RUN;
                    valid_d = 1'b1;
                end else if (redirect_valid) begin
                    pend_d = eff_t;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // The successor PC is re-registered from pc_d so it always tracks pc_f.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_VECTOR;
            pc_inc_q   <= RESET_VECTOR + XLEN'(INC);
            pend_q     <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_inc_q   <= pc_d + XLEN'(INC);
            pend_q     <= pend_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_f             = pc_q;
    assign pc_plus_inc_f    = pc_inc_q;
    assign fetch_valid      = valid_q;
    assign redirect_pending = (state_q == WAIT);
    assign misalign_err     = misalign_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit: each step drives one cycle of inputs,
// queues the hand-derived expected outputs and checks them after the edge.
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallF;
    logic        imemReady;
    logic        redirectValid;
    logic [31:0] redirectTarget;
    logic [31:0] pcF;
    logic [31:0] pcPlusIncF;
    logic        fetchValid;
    logic        redirectPending;
    logic        misalignErr;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] pcInc;
        logic        valid;
        logic        pending;
        logic        misalign;
    } expect_t;

    expect_t sbQ[$];
    int      vectors     = 0;
    int      miscompares = 0;

    pc_gen_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall_f         (stallF),
        .imem_ready      (imemReady),
        .redirect_valid  (redirectValid),
        .redirect_target (redirectTarget),
        .pc_f            (pcF),
        .pc_plus_inc_f   (pcPlusIncF),
        .fetch_valid     (fetchValid),
        .redirect_pending(redirectPending),
        .misalign_err    (misalignErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput();
        expect_t e;
        if (sbQ.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL scoreboard empty observed=0 expected=1");
            return;
        end
        e = sbQ.pop_front();
        vectors++;
        assert (pcF === e.pc) else begin
            miscompares++;
            $error("[TB] FAIL %s.pc_f observed=%h expected=%h", e.tag, pcF, e.pc);
        end
        vectors++;
        assert (pcPlusIncF === e.pcInc) else begin
            miscompares++;
            $error("[TB] FAIL %s.pc_plus_inc_f observed=%h expected=%h", e.tag, pcPlusIncF, e.pcInc);
        end
        vectors++;
        assert (fetchValid === e.valid) else begin
            miscompares++;
            $error("[TB] FAIL %s.fetch_valid observed=%b expected=%b", e.tag, fetchValid, e.valid);
        end
        vectors++;
        assert (redirectPending === e.pending) else begin
            miscompares++;
            $error("[TB] FAIL %s.redirect_pending observed=%b expected=%b", e.tag, redirectPending, e.pending);
        end
        vectors++;
        assert (misalignErr === e.misalign) else begin
            miscompares++;
            $error("[TB] FAIL %s.misalign_err observed=%b expected=%b", e.tag, misalignErr, e.misalign);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic applyStimulus(input string tag, input logic r, input logic s,
                                 input logic rdy, input logic rv, input logic [31:0] tgt,
                                 input logic [31:0] ePc, input logic [31:0] eInc,
                                 input logic eValid, input logic ePend, input logic eMis);
        expect_t e;
        @(negedge clk);
        rst            = r;
        stallF         = s;
        imemReady      = rdy;
        redirectValid  = rv;
        redirectTarget = tgt;
        e.tag      = tag;
        e.pc       = ePc;
        e.pcInc    = eInc;
        e.valid    = eValid;
        e.pending  = ePend;
        e.misalign = eMis;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst = 1'b1; stallF = 1'b0; imemReady = 1'b1;
        redirectValid = 1'b0; redirectTarget = '0;

        //             tag          rst  stl  rdy  rv   target        pc            pc+inc        fv   rp   me
        applyStimulus("reset1",     1,   0,   1,   0,   32'h0,        32'h0,        32'h4,        0,   0,   0);
        applyStimulus("reset2",     1,   0,   1,   0,   32'h0,        32'h0,        32'h4,        0,   0,   0);
        applyStimulus("run0",       0,   0,   1,   0,   32'h0,        32'h0,        32'h4,        1,   0,   0);
        applyStimulus("run4",       0,   0,   1,   0,   32'h0,        32'h4,        32'h8,        1,   0,   0);
        applyStimulus("run8",       0,   0,   1,   0,   32'h0,        32'h8,        32'hC,        1,   0,   0);
        applyStimulus("stall1",     0,   1,   1,   0,   32'h0,        32'h8,        32'hC,        1,   0,   0);
        applyStimulus("stall2",     0,   1,   1,   0,   32'h0,        32'h8,        32'hC,        1,   0,   0);
        applyStimulus("stall3",     0,   1,   1,   0,   32'h0,        32'h8,        32'hC,        1,   0,   0);
        applyStimulus("release",    0,   0,   1,   0,   32'h0,        32'hC,        32'h10,       1,   0,   0);
        applyStimulus("run10",      0,   0,   1,   0,   32'h0,        32'h10,       32'h14,       1,   0,   0);
        applyStimulus("bpRedir",    0,   0,   0,   1,   32'h200,      32'h10,       32'h14,       0,   1,   0);
        applyStimulus("bpWait1",    0,   0,   0,   0,   32'h0,        32'h10,       32'h14,       0,   1,   0);
        applyStimulus("bpWait2",    0,   0,   0,   0,   32'h0,        32'h10,       32'h14,       0,   1,   0);
        applyStimulus("bpExit",     0,   0,   1,   0,   32'h0,        32'h200,      32'h204,      1,   0,   0);
        applyStimulus("run204",     0,   0,   1,   0,   32'h0,        32'h204,      32'h208,      1,   0,   0);
        applyStimulus("lwFirst",    0,   0,   0,   1,   32'h200,      32'h204,      32'h208,      0,   1,   0);
        applyStimulus("lwSecond",   0,   0,   0,   1,   32'h300,      32'h204,      32'h208,      0,   1,   0);
        applyStimulus("lwExit",     0,   0,   1,   0,   32'h0,        32'h300,      32'h304,      1,   0,   0);
        applyStimulus("stlRedir",   0,   1,   1,   1,   32'h400,      32'h300,      32'h304,      0,   1,   0);
        applyStimulus("waitNewRd",  0,   0,   1,   1,   32'h500,      32'h500,      32'h504,      1,   0,   0);
        applyStimulus("misAdv",     0,   0,   1,   1,   32'h202,      32'h100,      32'h104,      1,   0,   1);
        applyStimulus("misClear",   0,   0,   1,   0,   32'h0,        32'h104,      32'h108,      1,   0,   0);
        applyStimulus("misWait",    0,   0,   0,   1,   32'h203,      32'h104,      32'h108,      0,   1,   1);
        applyStimulus("misWaitEx",  0,   0,   1,   0,   32'h0,        32'h100,      32'h104,      1,   0,   0);
        applyStimulus("ignoreTgt",  0,   0,   1,   0,   32'h7,        32'h104,      32'h108,      1,   0,   0);
        applyStimulus("toTop",      0,   0,   1,   1,   32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,      1,   0,   0);
        applyStimulus("wrap",       0,   0,   1,   0,   32'h0,        32'h0,        32'h4,        1,   0,   0);
        applyStimulus("run4b",      0,   0,   1,   0,   32'h0,        32'h4,        32'h8,        1,   0,   0);
        applyStimulus("preRstWait", 0,   0,   0,   1,   32'h600,      32'h4,        32'h8,        0,   1,   0);
        applyStimulus("rstInWait",  1,   0,   1,   0,   32'h0,        32'h0,        32'h4,        0,   0,   0);
        applyStimulus("postRst0",   0,   0,   1,   0,   32'h0,        32'h0,        32'h4,        1,   0,   0);
        applyStimulus("postRst4",   0,   0,   1,   0,   32'h0,        32'h4,        32'h8,        1,   0,   0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
